// File: rtl/completion_tracker_if.sv
// Rename, execution-port and commit signals of the in-order completion tracker.
// The master side is rename and the execution cluster. The slave side is the tracker.
interface completion_tracker_if #(
  parameter int PACKS = 16
);
  localparam int IW = $clog2(PACKS);

  logic          alloc_valid_i;
  logic [1:0]    alloc_mask_i;
  logic [IW-1:0] alloc_pack_o;
  logic          alloc_full_o;
  logic          alu0_complete_i;
  logic [IW:0]   alu0_rob_id_i;
  logic          alu1_complete_i;
  logic [IW:0]   alu1_rob_id_i;
  logic          mem_complete_i;
  logic [IW:0]   mem_rob_id_i;
  logic          excp_valid_i;
  logic [IW+1:0] excp_rob_i;
  logic [4:0]    excp_code_i;
  logic          commit_valid_o;
  logic [IW-1:0] commit_pack_o;
  logic [1:0]    commit_mask_o;
  logic          trap_valid_o;
  logic [IW:0]   trap_rob_o;
  logic [4:0]    trap_code_o;
  logic          flush_o;

  modport master (
    output alloc_valid_i, alloc_mask_i, alu0_complete_i, alu0_rob_id_i,
           alu1_complete_i, alu1_rob_id_i, mem_complete_i, mem_rob_id_i,
           excp_valid_i, excp_rob_i, excp_code_i,
    input  alloc_pack_o, alloc_full_o, commit_valid_o, commit_pack_o,
           commit_mask_o, trap_valid_o, trap_rob_o, trap_code_o, flush_o
  );

  modport slave (
    input  alloc_valid_i, alloc_mask_i, alu0_complete_i, alu0_rob_id_i,
           alu1_complete_i, alu1_rob_id_i, mem_complete_i, mem_rob_id_i,
           excp_valid_i, excp_rob_i, excp_code_i,
    output alloc_pack_o, alloc_full_o, commit_valid_o, commit_pack_o,
           commit_mask_o, trap_valid_o, trap_rob_o, trap_code_o, flush_o
  );
endinterface

// File: rtl/completion_tracker.sv
// In-order completion tracker that holds packs of two slots and retires whole packs from the head.
// A faulting head raises a precise trap and spends one cycle flushing every live pack.
module completion_tracker #(
  parameter int PACKS = 16
) (
  input logic                 cpu_clock_i,
  input logic                 cpu_reset_n_i,
  completion_tracker_if.slave bus
);
  localparam int IW = $clog2(PACKS);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e           state_q;
  logic [IW:0]      head_q, tail_q;
  logic [PACKS-1:0] vld_q, vld_d;
  logic [1:0]       slot_vld_q [PACKS];
  logic [1:0]       slot_vld_d [PACKS];
  logic [1:0]       done_q [PACKS];
  logic [1:0]       done_d [PACKS];
  logic [1:0]       excp_q [PACKS];
  logic [1:0]       excp_d [PACKS];
  logic [4:0]       code_q [PACKS];
  logic [4:0]       code_d [PACKS];

  logic             commit_valid_q, trap_valid_q, flush_q;
  logic [IW-1:0]    commit_pack_q;
  logic [1:0]       commit_mask_q;
  logic [IW:0]      trap_rob_q;
  logic [4:0]       trap_code_q;

  logic [IW-1:0]    head_idx, tail_idx, ex_idx;
  logic             ex_slot, full, head_ready, alloc_ok;
  logic             comp_v [3];
  logic [IW:0]      comp_id [3];

  assign head_idx = head_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];
  assign ex_idx   = bus.excp_rob_i[IW:1];
  assign ex_slot  = bus.excp_rob_i[0];
  assign full     = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);

  // Fullness is judged before this cycle's commit, so a full tracker turns away a same-cycle alloc.
  assign bus.alloc_full_o = full || (state_q != RUN);
  assign bus.alloc_pack_o = tail_idx;
  assign alloc_ok   = bus.alloc_valid_i && !bus.alloc_full_o && (bus.alloc_mask_i != 2'b00);
  assign head_ready = (state_q == RUN) && vld_q[head_idx] &&
                      ((done_q[head_idx] | ~slot_vld_q[head_idx]) == 2'b11);

  always_comb begin
    comp_v[0]  = bus.alu0_complete_i;
    comp_id[0] = bus.alu0_rob_id_i;
    comp_v[1]  = bus.alu1_complete_i;
    comp_id[1] = bus.alu1_rob_id_i;
    comp_v[2]  = bus.mem_complete_i;
    comp_id[2] = bus.mem_rob_id_i;
  end

  // NOTE: every next-state array starts as a copy of its register so no path can infer a latch.
  always_comb begin
    vld_d      = vld_q;
    slot_vld_d = slot_vld_q;
    done_d     = done_q;
    excp_d     = excp_q;
    code_d     = code_q;
    if (state_q == FLUSH) begin
      vld_d = '0;
    end else begin
      if (head_ready) vld_d[head_idx] = 1'b0;
      if (alloc_ok) begin
        vld_d[tail_idx]      = 1'b1;
        slot_vld_d[tail_idx] = bus.alloc_mask_i;
        done_d[tail_idx]     = ~bus.alloc_mask_i;
        excp_d[tail_idx]     = 2'b00;
      end
      for (int p = 0; p < 3; p++) begin
        if (comp_v[p] && vld_q[comp_id[p][IW:1]] && slot_vld_q[comp_id[p][IW:1]][comp_id[p][0]])
          done_d[comp_id[p][IW:1]][comp_id[p][0]] = 1'b1;
      end
      if (bus.excp_valid_i && vld_q[ex_idx] && slot_vld_q[ex_idx][ex_slot]) begin
        done_d[ex_idx][ex_slot] = 1'b1;
        // Keep the first fault of a pack unless the new one is in the older slot.
        if (excp_q[ex_idx] == 2'b00 || (!ex_slot && !excp_q[ex_idx][0])) begin
          excp_d[ex_idx] = ex_slot ? 2'b10 : 2'b01;
          code_d[ex_idx] = bus.excp_code_i;
        end
      end
    end
  end

  // NOTE: the pack payload has no reset because nothing reads it while vld_q is clear.
  always_ff @(posedge cpu_clock_i) begin
    slot_vld_q <= slot_vld_d;
    done_q     <= done_d;
    excp_q     <= excp_d;
    code_q     <= code_d;
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
    if (!cpu_reset_n_i) begin
      state_q        <= RUN;
      head_q         <= '0;
      tail_q         <= '0;
      vld_q          <= '0;
      commit_valid_q <= 1'b0;
      commit_pack_q  <= '0;
      commit_mask_q  <= 2'b00;
      trap_valid_q   <= 1'b0;
      trap_rob_q     <= '0;
      trap_code_q    <= 5'd0;
      flush_q        <= 1'b0;
    end else begin
      vld_q          <= vld_d;
      commit_valid_q <= 1'b0;
      commit_pack_q  <= '0;
      commit_mask_q  <= 2'b00;
      trap_valid_q   <= 1'b0;
      trap_rob_q     <= '0;
      trap_code_q    <= 5'd0;
      flush_q        <= 1'b0;
      if (alloc_ok) tail_q <= tail_q + (IW+1)'(1);
      case (state_q)
        RUN: begin
          if (head_ready) begin
            if (excp_q[head_idx] == 2'b00) begin
              commit_valid_q <= 1'b1;
              commit_pack_q  <= head_idx;
              commit_mask_q  <= slot_vld_q[head_idx];
              head_q         <= head_q + (IW+1)'(1);
            end else begin
              state_q      <= FLUSH;
              trap_valid_q <= 1'b1;
              flush_q      <= 1'b1;
              trap_code_q  <= code_q[head_idx];
              if (excp_q[head_idx][0]) begin
                trap_rob_q <= {head_idx, 1'b0};
              end else begin
                // Slot 0 retires ahead of the faulting slot 1; head stays on the faulting pack.
                trap_rob_q     <= {head_idx, 1'b1};
                commit_valid_q <= slot_vld_q[head_idx][0];
                commit_pack_q  <= slot_vld_q[head_idx][0] ? head_idx : '0;
                commit_mask_q  <= {1'b0, slot_vld_q[head_idx][0]};
              end
            end
          end
        end
        FLUSH: begin
          tail_q  <= head_q;
          state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.commit_valid_o = commit_valid_q;
  assign bus.commit_pack_o  = commit_pack_q;
  assign bus.commit_mask_o  = commit_mask_q;
  assign bus.trap_valid_o   = trap_valid_q;
  assign bus.trap_rob_o     = trap_rob_q;
  assign bus.trap_code_o    = trap_code_q;
  assign bus.flush_o        = flush_q;
endmodule
